// File: rtl/lc3b_types.sv
// Shared LC-3b types: rename register file defaults, commit lane and entry structs.
// No logic; constants and typedefs only.
// Not applicable: no handshake.
package lc3b_types;

    localparam int RRF_NUM_REGS   = 8;
    localparam int RRF_REG_W      = $clog2(RRF_NUM_REGS);
    localparam int RRF_DATA_W     = 16;
    localparam int RRF_TAG_W      = 3;
    localparam int RRF_NUM_RD     = 2;
    localparam int RRF_NUM_COMMIT = 2;

    // One ROB retire lane at default widths ("reg" is a keyword, hence areg).
    typedef struct packed {
        logic                  valid;
        logic [RRF_REG_W-1:0]  areg;
        logic [RRF_TAG_W-1:0]  tag;
        logic [RRF_DATA_W-1:0] data;
    } commit_lane_t;

    typedef struct packed {
        logic                  busy;
        logic [RRF_TAG_W-1:0]  tag;
        logic [RRF_DATA_W-1:0] data;
    } regfile_t;

endpackage

// File: rtl/rrf_entry_next.sv
// Next-state merge for one rename entry: commit lanes, then dispatch, then flush.
// Latency: combinational.
// Backpressure: none; every valid lane and dispatch is consumed in the same cycle.
module rrf_entry_next
    import lc3b_types::*;
#(
    parameter int NUM_REGS   = RRF_NUM_REGS,
    parameter int DATA_W     = RRF_DATA_W,
    parameter int TAG_W      = RRF_TAG_W,
    parameter int NUM_COMMIT = RRF_NUM_COMMIT,
    parameter int IDX        = 0
) (
    input  logic                                   cur_busy,
    input  logic [TAG_W-1:0]                       cur_tag,
    input  logic [DATA_W-1:0]                      cur_data,
    input  logic                                   flush,
    input  logic                                   disp_valid,
    input  logic [$clog2(NUM_REGS)-1:0]            disp_reg,
    input  logic [TAG_W-1:0]                       disp_tag,
    input  logic [NUM_COMMIT-1:0]                  cm_valid,
    input  logic [NUM_COMMIT*$clog2(NUM_REGS)-1:0] cm_reg,
    input  logic [NUM_COMMIT*TAG_W-1:0]            cm_tag,
    input  logic [NUM_COMMIT*DATA_W-1:0]           cm_data,
    output logic                                   nxt_busy,
    output logic [TAG_W-1:0]                       nxt_tag,
    output logic [DATA_W-1:0]                      nxt_data
);

    localparam int RW = $clog2(NUM_REGS);
    localparam logic [RW-1:0] MY_REG = RW'(IDX);

    always_comb begin
        nxt_busy = cur_busy;
        nxt_tag  = cur_tag;
        nxt_data = cur_data;
        // Later lanes overwrite data; busy clears only for the current owner's tag.
        for (int k = 0; k < NUM_COMMIT; k++) begin
            if (cm_valid[k] && cm_reg[k*RW +: RW] == MY_REG) begin
                nxt_data = cm_data[k*DATA_W +: DATA_W];
                if (cm_tag[k*TAG_W +: TAG_W] == cur_tag)
                    nxt_busy = 1'b0;
            end
        end
        if (flush) begin
            nxt_busy = 1'b0;
        end else if (disp_valid && disp_reg == MY_REG) begin
            nxt_busy = 1'b1;
            nxt_tag  = disp_tag;
        end
    end

endmodule

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename status and commit bypass on reads.
// Latency: reads combinational; commit/dispatch/flush take effect at the next clk edge.
// Backpressure: none; always accepts dispatch and all commit lanes.
module rename_regfile
    import lc3b_types::*;
#(
    parameter int NUM_REGS   = RRF_NUM_REGS,
    parameter int DATA_W     = RRF_DATA_W,
    parameter int TAG_W      = RRF_TAG_W,
    parameter int NUM_RD     = RRF_NUM_RD,
    parameter int NUM_COMMIT = RRF_NUM_COMMIT
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   disp_valid,
    input  logic [$clog2(NUM_REGS)-1:0]            disp_reg,
    input  logic [TAG_W-1:0]                       disp_tag,
    input  logic [NUM_RD*$clog2(NUM_REGS)-1:0]     rd_reg,
    output logic [NUM_RD-1:0]                      rd_busy,
    output logic [NUM_RD*TAG_W-1:0]                rd_tag,
    output logic [NUM_RD*DATA_W-1:0]               rd_data,
    input  logic [NUM_COMMIT-1:0]                  cm_valid,
    input  logic [NUM_COMMIT*$clog2(NUM_REGS)-1:0] cm_reg,
    input  logic [NUM_COMMIT*TAG_W-1:0]            cm_tag,
    input  logic [NUM_COMMIT*DATA_W-1:0]           cm_data
);

    localparam int RW = $clog2(NUM_REGS);

    logic [NUM_REGS-1:0]              busy_q, busy_d;
    logic [NUM_REGS-1:0][TAG_W-1:0]   tag_q,  tag_d;
    logic [NUM_REGS-1:0][DATA_W-1:0]  data_q, data_d;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        rrf_entry_next #(
            .NUM_REGS   (NUM_REGS),
            .DATA_W     (DATA_W),
            .TAG_W      (TAG_W),
            .NUM_COMMIT (NUM_COMMIT),
            .IDX        (i)
        ) u_next (
            .cur_busy   (busy_q[i]),
            .cur_tag    (tag_q[i]),
            .cur_data   (data_q[i]),
            .flush      (flush),
            .disp_valid (disp_valid),
            .disp_reg   (disp_reg),
            .disp_tag   (disp_tag),
            .cm_valid   (cm_valid),
            .cm_reg     (cm_reg),
            .cm_tag     (cm_tag),
            .cm_data    (cm_data),
            .nxt_busy   (busy_d[i]),
            .nxt_tag    (tag_d[i]),
            .nxt_data   (data_d[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            tag_q  <= '0;
            data_q <= '0;
        end else begin
            busy_q <= busy_d;
            tag_q  <= tag_d;
            data_q <= data_d;
        end
    end

    // Commit bypass: youngest matching lane wins; dispatch is deliberately not bypassed.
    always_comb begin
        logic [RW-1:0]     sel;
        logic              b;
        logic [TAG_W-1:0]  t;
        logic [DATA_W-1:0] d;
        rd_busy = '0;
        rd_tag  = '0;
        rd_data = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            sel = rd_reg[p*RW +: RW];
            b   = busy_q[sel];
            t   = tag_q[sel];
            d   = data_q[sel];
            for (int k = 0; k < NUM_COMMIT; k++) begin
                if (!rst && cm_valid[k] && cm_reg[k*RW +: RW] == sel &&
                    cm_tag[k*TAG_W +: TAG_W] == t) begin
                    b = 1'b0;
                    d = cm_data[k*DATA_W +: DATA_W];
                end
            end
            rd_busy[p]                 = b;
            rd_tag[p*TAG_W +: TAG_W]   = t;
            rd_data[p*DATA_W +: DATA_W] = d;
        end
    end

endmodule

// File: tb/tb_rename_regfile.sv
// Scoreboard bench for rename_regfile: directed scenarios then random traffic vs a reference model.
module tb_rename_regfile;
    import lc3b_types::*;

    localparam int NR = 8, DW = 16, TW = 3, NRD = 2, NC = 2, RW = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              disp_valid;
    logic [RW-1:0]     disp_reg;
    logic [TW-1:0]     disp_tag;
    logic [NRD*RW-1:0] rd_reg;
    logic [NRD-1:0]    rd_busy;
    logic [NRD*TW-1:0] rd_tag;
    logic [NRD*DW-1:0] rd_data;
    logic [NC-1:0]     cm_valid;
    logic [NC*RW-1:0]  cm_reg;
    logic [NC*TW-1:0]  cm_tag;
    logic [NC*DW-1:0]  cm_data;

    always #5 clk = ~clk;

    rename_regfile #(
        .NUM_REGS(NR), .DATA_W(DW), .TAG_W(TW), .NUM_RD(NRD), .NUM_COMMIT(NC)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_reg(disp_reg), .disp_tag(disp_tag),
        .rd_reg(rd_reg), .rd_busy(rd_busy), .rd_tag(rd_tag), .rd_data(rd_data),
        .cm_valid(cm_valid), .cm_reg(cm_reg), .cm_tag(cm_tag), .cm_data(cm_data)
    );

    typedef struct packed {
        logic [NRD-1:0]    busy;
        logic [NRD*TW-1:0] tag;
        logic [NRD*DW-1:0] data;
    } exp_t;

    regfile_t     m [NR];
    commit_lane_t lanes [NC];
    exp_t         exp_q [$];
    event         sample_ev;
    int           n_vec = 0;
    int           n_err = 0;

    function automatic commit_lane_t mk(input logic v, input logic [RW-1:0] r,
                                        input logic [TW-1:0] t, input logic [DW-1:0] d);
        commit_lane_t l;
        l.valid = v; l.areg = r; l.tag = t; l.data = d;
        return l;
    endfunction

    // A read sees the stored entry unless a valid lane retires its current producer.
    function automatic regfile_t predict(input logic [RW-1:0] r);
        regfile_t e;
        e = m[r];
        for (int k = NC - 1; k >= 0; k--) begin
            if (lanes[k].valid && lanes[k].areg == r && lanes[k].tag == m[r].tag) begin
                e.busy = 1'b0;
                e.data = lanes[k].data;
                break;
            end
        end
        return e;
    endfunction

    function automatic void model_clock(input logic fl, input logic dv,
                                        input logic [RW-1:0] dr, input logic [TW-1:0] dt);
        regfile_t old [NR];
        old = m;
        for (int k = 0; k < NC; k++) begin
            if (lanes[k].valid) begin
                m[lanes[k].areg].data = lanes[k].data;
                if (lanes[k].tag == old[lanes[k].areg].tag)
                    m[lanes[k].areg].busy = 1'b0;
            end
        end
        if (fl) begin
            for (int i = 0; i < NR; i++) m[i].busy = 1'b0;
        end else if (dv) begin
            m[dr].busy = 1'b1;
            m[dr].tag  = dt;
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NR; i++) m[i] = '0;
    endfunction

    function automatic exp_t expect_reads(input logic [RW-1:0] r0, input logic [RW-1:0] r1);
        exp_t x;
        regfile_t e0, e1;
        e0 = predict(r0);
        e1 = predict(r1);
        x.busy = {e1.busy, e0.busy};
        x.tag  = {e1.tag, e0.tag};
        x.data = {e1.data, e0.data};
        return x;
    endfunction

    task automatic drive_lanes();
        cm_valid = {lanes[1].valid, lanes[0].valid};
        cm_reg   = {lanes[1].areg,  lanes[0].areg};
        cm_tag   = {lanes[1].tag,   lanes[0].tag};
        cm_data  = {lanes[1].data,  lanes[0].data};
    endtask

    task automatic step(input commit_lane_t l0, input commit_lane_t l1,
                        input logic dv, input logic [RW-1:0] dr, input logic [TW-1:0] dt,
                        input logic fl, input logic [RW-1:0] r0, input logic [RW-1:0] r1);
        @(negedge clk);
        lanes[0] = l0;
        lanes[1] = l1;
        drive_lanes();
        disp_valid = dv; disp_reg = dr; disp_tag = dt;
        flush = fl;
        rd_reg = {r1, r0};
        exp_q.push_back(expect_reads(r0, r1));
        -> sample_ev;
        @(posedge clk);
        model_clock(fl, dv, dr, dt);
    endtask

    task automatic chk(input string nm, input int p, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %h, expected %h", nm, p, $time, act, req);
        end
    endtask

    // Monitor: pops one expectation per presented read sample.
    initial begin
        exp_t x;
        forever begin
            @(sample_ev);
            #1;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_underflow at %0t", $time);
            end else begin
                x = exp_q.pop_front();
                for (int p = 0; p < NRD; p++) begin
                    chk("rd_busy", p, 32'(rd_busy[p]),          32'(x.busy[p]));
                    chk("rd_tag",  p, 32'(rd_tag[p*TW +: TW]),  32'(x.tag[p*TW +: TW]));
                    chk("rd_data", p, 32'(rd_data[p*DW +: DW]), 32'(x.data[p*DW +: DW]));
                end
            end
        end
    end

    initial begin
        #400000;
        n_err++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        commit_lane_t nol;
        commit_lane_t a, b;
        int nv;
        nol = '0;
        rst = 1'b1; flush = 0; disp_valid = 0; disp_reg = 0; disp_tag = 0;
        rd_reg = 0; cm_valid = 0; cm_reg = 0; cm_tag = 0; cm_data = 0;
        lanes[0] = nol; lanes[1] = nol;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset state, then build R1 busy tag=5 and R2 data=0x1234.
        step(nol, nol, 0, 0, 0, 0, 3'd0, 3'd1);
        step(mk(1, 3'd2, 3'd0, 16'h1234), nol, 1, 3'd1, 3'd5, 0, 3'd1, 3'd2);
        step(nol, nol, 0, 0, 0, 0, 3'd1, 3'd2);

        // Asynchronous reset mid-cycle: outputs must clear before the next edge.
        @(posedge clk);
        #2;
        lanes[0] = nol; lanes[1] = nol;
        drive_lanes();
        disp_valid = 0; flush = 0;
        rd_reg = {3'd2, 3'd1};
        rst = 1'b1;
        model_reset();
        exp_q.push_back(expect_reads(3'd1, 3'd2));
        -> sample_ev;
        @(negedge clk);
        rst = 1'b0;
        step(nol, nol, 0, 0, 0, 0, 3'd1, 3'd2);

        // Dispatch R3, read pending, commit bypass, then committed state.
        step(nol, nol, 1, 3'd3, 3'd2, 0, 3'd3, 3'd0);
        step(nol, nol, 0, 0, 0, 0, 3'd3, 3'd0);
        step(mk(1, 3'd3, 3'd2, 16'hBEEF), nol, 0, 0, 0, 0, 3'd3, 3'd3);
        step(nol, nol, 0, 0, 0, 0, 3'd3, 3'd0);

        // Stale commit leaves the newer producer in place.
        step(nol, nol, 1, 3'd4, 3'd1, 0, 3'd4, 3'd0);
        step(nol, nol, 1, 3'd4, 3'd3, 0, 3'd4, 3'd0);
        step(mk(1, 3'd4, 3'd1, 16'h0011), nol, 0, 0, 0, 0, 3'd4, 3'd0);
        step(mk(1, 3'd4, 3'd3, 16'h0033), nol, 0, 0, 0, 0, 3'd4, 3'd4);
        step(nol, nol, 0, 0, 0, 0, 3'd4, 3'd0);

        // Two lanes on one register: lane 1 holds the owning tag.
        step(nol, nol, 1, 3'd5, 3'd5, 0, 3'd5, 3'd0);
        step(mk(1, 3'd5, 3'd4, 16'hAAAA), mk(1, 3'd5, 3'd5, 16'h5555), 0, 0, 0, 0, 3'd5, 3'd5);
        step(nol, nol, 0, 0, 0, 0, 3'd5, 3'd0);

        // Commit and dispatch on the same register in one cycle.
        step(nol, nol, 1, 3'd6, 3'd6, 0, 3'd6, 3'd0);
        step(mk(1, 3'd6, 3'd6, 16'h0F0F), nol, 1, 3'd6, 3'd7, 0, 3'd6, 3'd6);
        step(nol, nol, 0, 0, 0, 0, 3'd6, 3'd0);

        // Flush keeps same-cycle commit data and drops same-cycle dispatch.
        step(nol, nol, 1, 3'd1, 3'd1, 0, 3'd1, 3'd0);
        step(nol, nol, 1, 3'd2, 3'd2, 0, 3'd2, 3'd0);
        step(nol, nol, 1, 3'd7, 3'd3, 0, 3'd7, 3'd0);
        step(mk(1, 3'd2, 3'd2, 16'h2222), nol, 1, 3'd0, 3'd1, 1, 3'd1, 3'd7);
        step(nol, nol, 0, 0, 0, 0, 3'd0, 3'd2);
        step(nol, nol, 0, 0, 0, 0, 3'd1, 3'd7);

        // Random traffic; commit tags mostly hit the current owner.
        for (int it = 0; it < 400; it++) begin
            logic [RW-1:0] ra, rb;
            ra = RW'($urandom_range(0, NR - 1));
            rb = RW'($urandom_range(0, NR - 1));
            a = mk(1'b0, ra, ($urandom_range(0, 3) == 0) ? TW'($urandom) : m[ra].tag, DW'($urandom));
            b = mk(1'b0, rb, ($urandom_range(0, 3) == 0) ? TW'($urandom) : m[rb].tag, DW'($urandom));
            nv = $urandom_range(0, 9);
            if (nv >= 3) a.valid = 1'b1;
            if (nv >= 6 || nv == 0) b.valid = 1'b1;
            step(a, b, 1'($urandom), RW'($urandom), TW'($urandom),
                 ($urandom_range(0, 19) == 0), RW'($urandom), RW'($urandom));
        end

        @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_leftover: %0d entries, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rename_regfile.md
Name: rename_regfile

Overview:
- Parametrised architectural register file with rename status for the out-of-order LC-3b core.
- Each register holds a busy bit, the ROB tag of its newest in-flight producer, and committed data.
- Sits between decode/dispatch (source lookup, destination rename) and the ROB retire stage. Retire is generalised to NUM_COMMIT in-order lanes per cycle.
- Supports a full-pipeline flush on branch mispredict.

Parameters:
- NUM_REGS, 8, number of architectural registers (power of 2)
- DATA_W, 16, register data width
- TAG_W, 3, ROB tag width
- NUM_RD, 2, source read ports
- NUM_COMMIT, 2, retire lanes per cycle; lane 0 is oldest

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- flush  in  1  mispredict flush, clears all rename state
- disp_valid  in  1  dispatch renames a destination this cycle
- disp_reg  in  log2(NUM_REGS)  destination register
- disp_tag  in  TAG_W  ROB tag of the dispatching instruction
- rd_reg  in  NUM_RD*log2(NUM_REGS)  source register per read port
- rd_busy  out  NUM_RD  source still pending
- rd_tag  out  NUM_RD*TAG_W  producer tag (valid when busy)
- rd_data  out  NUM_RD*DATA_W  register value (valid when not busy)
- cm_valid  in  NUM_COMMIT  retire lane valid
- cm_reg  in  NUM_COMMIT*log2(NUM_REGS)  retiring destination
- cm_tag  in  NUM_COMMIT*TAG_W  retiring ROB tag
- cm_data  in  NUM_COMMIT*DATA_W  retiring value

Behaviour:
- Reset (async, rst=1): every entry busy=0, tag=0, data=0. Outputs are combinational from state, so rd_busy=0, rd_tag=0, rd_data=0. rst overrides every other input.
- Read ports are combinational, with zero latency from rd_reg.
- Read ports see state after this cycle's commits, before this cycle's dispatch (commit bypass). If a valid lane k has cm_reg==rd_reg and cm_tag equals the entry tag, the port returns busy=0 and data=cm_data[k]. If several lanes match, the highest-indexed (youngest) matching lane wins.
- Same-cycle dispatch never affects reads. An instruction reading its own destination sees the prior producer.
- Commit (posedge):
  - For each valid lane, in lane order 0..NUM_COMMIT-1, data[cm_reg] <= cm_data. The later lane wins on the same reg.
  - busy[cm_reg] clears only if cm_tag equals the stored tag; otherwise a newer producer owns the register and busy/tag are untouched.
- Dispatch (posedge, disp_valid): busy[disp_reg]<=1, tag[disp_reg]<=disp_tag. Dispatch has priority over commit for busy/tag on the same reg; the commit still writes data.
- Flush (posedge): all busy<=0 after commits are applied, so same-cycle commit data is kept. Tags hold their values. Same-cycle dispatch is dropped.
- No internal FSM beyond per-entry state. Tag comparison is exact TAG_W-bit equality. Wrap-around of ROB tags is the ROB's responsibility: tag reuse while an older matching producer is unretired is illegal.
- The ROB guarantees commit lanes are contiguous from lane 0. A lane with cm_valid=0 followed by a valid lane is still processed correctly; there is no compaction.

Decomposition:
- Package lc3b_types gains:
  - RRF_NUM_REGS, RRF_TAG_W, RRF_NUM_COMMIT default constants
  - commit_lane_t struct packed {valid; reg; tag; data}
  - regfile_t (existing) reused as the entry type at default widths
- Sub-module rrf_entry_next: combinational per-register next-state merge of commit lanes, dispatch and flush, instantiated NUM_REGS times via generate.
- The top level holds the flop array, read muxes and commit bypass.

Test Plan:
- Reset mid-operation: entries R1 busy tag=5, R2 data=0x1234; assert rst asynchronously mid-cycle -> all rd_busy=0, rd_data=0 immediately, before the next clock edge.
- Dispatch R3 tag=2, next cycle read R3 -> rd_busy=1, rd_tag=2; commit lane0 R3 tag=2 data=0xBEEF same cycle as read -> bypass gives busy=0, data=0xBEEF; next cycle state matches.
- Stale commit: dispatch R4 tag=1, then R4 tag=3; commit R4 tag=1 data=0x0011 -> data=0x0011 but busy=1, tag=3; commit tag=3 data=0x0033 -> busy=0, data=0x0033.
- Dual-lane same reg: lane0 R5 tag=4 data=0xAAAA, lane1 R5 tag=5 data=0x5555, entry tag=5 -> data=0x5555, busy=0; bypass read returns 0x5555.
- Dispatch+commit collision: entry R6 tag=6; commit R6 tag=6 data=0x0F0F with dispatch R6 tag=7 -> busy=1, tag=7, data=0x0F0F; same-cycle read of R6 shows busy=0, 0x0F0F.
- Flush: R1, R2, R7 busy; flush with commit R2 data=0x2222 and dispatch R0 tag=1 -> all busy=0, R2 data=0x2222, R0 not busy.
